// File: rtl/uart_pkg.sv
// Shared types and constants for the 16550-style register block: CSR snapshot,
// register addresses, IIR codes and the FCR receive-threshold decode.
package uart_pkg;

  localparam logic [3:0] ADDR_RBR  = 4'd0;
  localparam logic [3:0] ADDR_IER  = 4'd1;
  localparam logic [3:0] ADDR_IIR  = 4'd2;
  localparam logic [3:0] ADDR_LCR  = 4'd3;
  localparam logic [3:0] ADDR_MCR  = 4'd4;
  localparam logic [3:0] ADDR_LSR  = 4'd5;
  localparam logic [3:0] ADDR_MSR  = 4'd6;
  localparam logic [3:0] ADDR_SCR  = 4'd7;
  localparam logic [3:0] ADDR_DLX  = 4'd8;
  localparam logic [3:0] ADDR_FRAC = 4'd9;

  localparam logic [7:0] IIR_RLS  = 8'h06;
  localparam logic [7:0] IIR_RX   = 8'h04;
  localparam logic [7:0] IIR_THRE = 8'h02;
  localparam logic [7:0] IIR_NONE = 8'h01;

  localparam logic [7:0] LCR_RST  = 8'h03;

  // div is sized for the widest legal divisor; unused upper bits read as zero.
  typedef struct packed {
    logic [23:0] div;
    logic [7:0]  frac;
    logic [7:0]  lcr;
    logic [7:0]  ier;
    logic [7:0]  mcr;
    logic [7:0]  scr;
    logic [3:0]  thresh;
    logic [3:0]  lsr_err;   // {BI, FE, PE, OE}
    logic        thre_pend;
  } csr_t;

  function automatic logic [3:0] thr_decode(input logic [1:0] sel);
    case (sel)
      2'd0:    return 4'd1;
      2'd1:    return 4'd4;
      2'd2:    return 4'd8;
      default: return 4'd14;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one-cycle pulse every D cycles (none for D=0); reload restarts the count.
// UART_REGS_FRAC_EN adds a fractional accumulator whose carry stretches the next period by one.
module uart_baud_gen #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              baud_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d, target;
  logic             baud_q, baud_d;
  logic             stretch;

`ifdef UART_REGS_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              stretch_q, stretch_d;
  assign stretch = stretch_q;
`else
  logic unused_frac;
  assign unused_frac = ^frac_i;
  assign stretch     = 1'b0;
`endif

  // A stretched period ends one count later than a normal one.
  assign target = stretch ? div_i : div_i - {{(DIV_W-1){1'b0}}, 1'b1};

  always_comb begin
    cnt_d  = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
    baud_d = 1'b0;
`ifdef UART_REGS_FRAC_EN
    acc_d     = acc_q;
    stretch_d = stretch_q;
`endif
    if (reload_i) begin
      cnt_d = '0;
`ifdef UART_REGS_FRAC_EN
      acc_d     = '0;
      stretch_d = 1'b0;
`endif
    end else if (div_i == '0) begin
      cnt_d = '0;
    end else if (cnt_q == target) begin
      cnt_d  = '0;
      baud_d = 1'b1;
`ifdef UART_REGS_FRAC_EN
      {stretch_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_i};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      baud_q    <= 1'b0;
`ifdef UART_REGS_FRAC_EN
      acc_q     <= '0;
      stretch_q <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      baud_q    <= baud_d;
`ifdef UART_REGS_FRAC_EN
      acc_q     <= acc_d;
      stretch_q <= stretch_d;
`endif
    end
  end

  assign baud_o = baud_q;

endmodule

// File: rtl/uart_regs_p.sv
// 16550-style UART register file with sticky line status, IIR priority, FCR pulses and baud generator.
// Reads are combinational from addr_i; writes land on the clk edge. UART_REGS_FRAC_EN maps FRAC at addr 9.
module uart_regs_p
  import uart_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_i,
  input  logic       rd_i,
  input  logic [3:0] addr_i,
  input  logic [7:0] din_i,
  input  logic       rx_fifo_empty_i,
  input  logic [7:0] rx_fifo_in,
  input  logic [4:0] rx_fifo_count_i,
  input  logic       tx_fifo_empty_i,
  input  logic       tx_idle_i,
  input  logic       rx_oe,
  input  logic       rx_pe,
  input  logic       rx_fe,
  input  logic       rx_bi,
  output logic       tx_push_o,
  output logic       rx_pop_o,
  output logic       baud_out,
  output logic       tx_rst,
  output logic       rx_rst,
  output logic [3:0] rx_fifo_threshold,
  output logic [7:0] dout_o,
  output logic       irq_o,
  output csr_t       csr
);

  localparam logic [23:0] DIV_MASK = 24'((64'd1 << DIV_W) - 64'd1);

  logic [7:0]  lcr_q, lcr_d, ier_q, ier_d, mcr_q, mcr_d, scr_q, scr_d, frac_q, frac_d;
  logic [23:0] div_q, div_d;
  logic [3:0]  thr_q, thr_d, err_q, err_d;
  logic        thre_q, thre_d, txe_q, rx_rst_q, rx_rst_d, tx_rst_q, tx_rst_d, irq_q, irq_d;
  logic        dlab, reload;
  logic [7:0]  lsr, iir;

  assign dlab = lcr_q[7];
  assign lsr  = {|err_q, tx_fifo_empty_i & tx_idle_i, tx_fifo_empty_i, err_q, ~rx_fifo_empty_i};

  always_comb begin
    iir = IIR_NONE;
    if (ier_q[2] && lsr[7])                                iir = IIR_RLS;
    else if (ier_q[0] && (rx_fifo_count_i >= {1'b0, thr_q})) iir = IIR_RX;
    else if (ier_q[1] && thre_q)                           iir = IIR_THRE;
  end

  assign tx_push_o = wr_i && (addr_i == ADDR_RBR) && !dlab;
  assign rx_pop_o  = rd_i && (addr_i == ADDR_RBR) && !dlab && !rx_fifo_empty_i;

  always_comb begin
    lcr_d    = lcr_q;
    ier_d    = ier_q;
    mcr_d    = mcr_q;
    scr_d    = scr_q;
    frac_d   = frac_q;
    div_d    = div_q;
    thr_d    = thr_q;
    rx_rst_d = 1'b0;
    tx_rst_d = 1'b0;
    reload   = 1'b0;
    // A coincident error pulse overrides the read-clear so no event is lost.
    err_d    = (rd_i && addr_i == ADDR_LSR) ? 4'b0 : err_q;
    err_d    = err_d | {rx_bi, rx_fe, rx_pe, rx_oe};
    thre_d   = thre_q;
    if (tx_fifo_empty_i && !txe_q) thre_d = 1'b1;
    if (wr_i) begin
      case (addr_i)
        ADDR_RBR: if (dlab) begin div_d[7:0] = din_i; reload = 1'b1; end
                  else thre_d = 1'b0;
        ADDR_IER: if (dlab) begin div_d[15:8] = din_i; reload = 1'b1; end
                  else begin
                    ier_d = din_i;
                    if (din_i[1] && !ier_q[1] && tx_fifo_empty_i) thre_d = 1'b1;
                  end
        ADDR_IIR: begin
          thr_d    = thr_decode(din_i[7:6]);
          rx_rst_d = din_i[1];
          tx_rst_d = din_i[2];
        end
        ADDR_LCR: lcr_d = din_i;
        ADDR_MCR: mcr_d = din_i;
        ADDR_SCR: scr_d = din_i;
        ADDR_DLX: begin div_d[23:16] = din_i; reload = 1'b1; end
`ifdef UART_REGS_FRAC_EN
        ADDR_FRAC: frac_d = din_i;
`endif
        default: ;
      endcase
    end
    if (rd_i && addr_i == ADDR_IIR && iir == IIR_THRE) thre_d = 1'b0;
    div_d = div_d & DIV_MASK;
    irq_d = ~iir[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcr_q    <= LCR_RST;
      ier_q    <= '0;
      mcr_q    <= '0;
      scr_q    <= '0;
      frac_q   <= '0;
      div_q    <= '0;
      thr_q    <= 4'd1;
      err_q    <= '0;
      thre_q   <= 1'b0;
      txe_q    <= 1'b1;
      rx_rst_q <= 1'b0;
      tx_rst_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      lcr_q    <= lcr_d;
      ier_q    <= ier_d;
      mcr_q    <= mcr_d;
      scr_q    <= scr_d;
      frac_q   <= frac_d;
      div_q    <= div_d;
      thr_q    <= thr_d;
      err_q    <= err_d;
      thre_q   <= thre_d;
      txe_q    <= tx_fifo_empty_i;
      rx_rst_q <= rx_rst_d;
      tx_rst_q <= tx_rst_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    dout_o = 8'h00;
    case (addr_i)
      ADDR_RBR:  dout_o = dlab ? div_q[7:0] : rx_fifo_in;
      ADDR_IER:  dout_o = dlab ? div_q[15:8] : ier_q;
      ADDR_IIR:  dout_o = iir;
      ADDR_LCR:  dout_o = lcr_q;
      ADDR_MCR:  dout_o = mcr_q;
      ADDR_LSR:  dout_o = lsr;
      ADDR_SCR:  dout_o = scr_q;
      ADDR_DLX:  dout_o = div_q[23:16];
`ifdef UART_REGS_FRAC_EN
      ADDR_FRAC: dout_o = frac_q;
`endif
      default:   dout_o = 8'h00;
    endcase
  end

  uart_baud_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .reload_i (reload),
    .div_i    (div_q[DIV_W-1:0]),
    .frac_i   (frac_q[FRAC_W-1:0]),
    .baud_o   (baud_out)
  );

  assign tx_rst            = tx_rst_q;
  assign rx_rst            = rx_rst_q;
  assign irq_o             = irq_q;
  assign rx_fifo_threshold = thr_q;
  assign csr = '{div: div_q, frac: frac_q, lcr: lcr_q, ier: ier_q, mcr: mcr_q, scr: scr_q,
                 thresh: thr_q, lsr_err: err_q, thre_pend: thre_q};

endmodule

// File: tb/tb_uart_regs_p.sv
// Directed bench for uart_regs_p: register map, LSR/IIR/irq behaviour, FCR pulses and baud timing.
module tb_uart_regs_p;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_i, rd_i;
  logic [3:0] addr_i;
  logic [7:0] din_i;
  logic       rx_fifo_empty_i, tx_fifo_empty_i, tx_idle_i;
  logic [7:0] rx_fifo_in;
  logic [4:0] rx_fifo_count_i;
  logic       rx_oe, rx_pe, rx_fe, rx_bi;
  logic       tx_push_o, rx_pop_o, baud_out, tx_rst, rx_rst, irq_o;
  logic [3:0] rx_fifo_threshold;
  logic [7:0] dout_o;
  csr_t       csr;

  int n_chk  = 0;
  int n_pass = 0;

  uart_regs_p dut (
    .clk(clk), .rst(rst), .wr_i(wr_i), .rd_i(rd_i), .addr_i(addr_i), .din_i(din_i),
    .rx_fifo_empty_i(rx_fifo_empty_i), .rx_fifo_in(rx_fifo_in), .rx_fifo_count_i(rx_fifo_count_i),
    .tx_fifo_empty_i(tx_fifo_empty_i), .tx_idle_i(tx_idle_i),
    .rx_oe(rx_oe), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi),
    .tx_push_o(tx_push_o), .rx_pop_o(rx_pop_o), .baud_out(baud_out), .tx_rst(tx_rst),
    .rx_rst(rx_rst), .rx_fifo_threshold(rx_fifo_threshold), .dout_o(dout_o), .irq_o(irq_o),
    .csr(csr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); addr_i = a; din_i = d; wr_i = 1'b1;
    @(negedge clk); wr_i = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk); addr_i = a; rd_i = 1'b1;
    #1 d = dout_o;
    @(negedge clk); rd_i = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    addr_i = a;
    #1 d = dout_o;
  endtask

  task automatic wait_pulse(input int limit, output int c);
    c = 0;
    do begin @(negedge clk); c++; end while (!baud_out && c < limit);
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    repeat (n) begin @(negedge clk); if (baud_out) p++; end
  endtask

  task automatic pulse_pe();
    @(negedge clk); rx_pe = 1'b1;
    @(negedge clk); rx_pe = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int c, p;
    int exp_per[4];
`ifdef UART_REGS_FRAC_EN
    exp_per = '{4, 5, 4, 5};
`else
    exp_per = '{4, 4, 4, 4};
`endif
    rst = 1'b1; wr_i = 0; rd_i = 0; addr_i = 0; din_i = 0;
    rx_fifo_empty_i = 1; rx_fifo_in = 8'h5A; rx_fifo_count_i = 0;
    tx_fifo_empty_i = 1; tx_idle_i = 1;
    rx_oe = 0; rx_pe = 0; rx_fe = 0; rx_bi = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    peek(ADDR_LCR, d); chk("rst_lcr", d, 8'h03);
    peek(ADDR_IIR, d); chk("rst_iir", d, 8'h01);
    peek(ADDR_IER, d); chk("rst_ier", d, 8'h00);
    peek(ADDR_LSR, d); chk("rst_lsr", d, 8'h60);
    chk("rst_thresh", rx_fifo_threshold, 4'd1);
    chk("rst_outs", {irq_o, baud_out, tx_rst, rx_rst}, 4'b0000);
    chk("rst_div", csr.div, 24'h0);

    wr(ADDR_SCR, 8'hA5); peek(ADDR_SCR, d); chk("scr", d, 8'hA5);
    wr(4'd10, 8'hFF);    peek(4'd10, d);    chk("unmapped_rd", d, 8'h00);
    peek(ADDR_MSR, d); chk("msr", d, 8'h00);
    wr(ADDR_FRAC, 8'h03); peek(ADDR_FRAC, d);
`ifdef UART_REGS_FRAC_EN
    chk("frac_rd", d, 8'h03);
`else
    chk("frac_rd", d, 8'h00);
`endif
    wr(ADDR_FRAC, 8'h00);

    // divisor 0x108 = 264
    wr(ADDR_LCR, 8'h80); wr(ADDR_RBR, 8'h08); wr(ADDR_IER, 8'h01);
    chk("div_264", csr.div, 24'h108);
    peek(ADDR_RBR, d); chk("dll_rd", d, 8'h08);
    wr(ADDR_LCR, 8'h00);
    wait_pulse(600, c);
    wait_pulse(600, c); chk("period_264", c, 264);

    wr(ADDR_LCR, 8'h80); wr(ADDR_IER, 8'h00); wr(ADDR_RBR, 8'h01);
    count_pulses(10, p); chk("d1_pulses", p, 10);
    wr(ADDR_RBR, 8'h00);
    count_pulses(20, p); chk("d0_pulses", p, 0);

`ifdef UART_REGS_FRAC_EN
    wr(ADDR_FRAC, 8'h08);
`endif
    wr(ADDR_RBR, 8'h04);
    wait_pulse(20, c); chk("d4_first", c, 4);
    for (int i = 0; i < 4; i++) begin
      wait_pulse(20, c); chk($sformatf("d4_per%0d", i), c, exp_per[i]);
    end
    wr(ADDR_RBR, 8'h00); wr(ADDR_LCR, 8'h03);

    pulse_pe();
    peek(ADDR_IIR, d); chk("iir_masked", d, 8'h01);
    wr(ADDR_IER, 8'h04);
    chk("irq_lag", irq_o, 1'b0);
    peek(ADDR_IIR, d); chk("iir_rls", d, 8'h06);
    @(negedge clk); chk("irq_rls", irq_o, 1'b1);
    rd(ADDR_LSR, d); chk("lsr_pe", d, 8'hE4);
    peek(ADDR_LSR, d); chk("lsr_clr", d, 8'h60);
    peek(ADDR_IIR, d); chk("iir_clr", d, 8'h01);
    @(negedge clk); chk("irq_clr", irq_o, 1'b0);
    pulse_pe();
    @(negedge clk); addr_i = ADDR_LSR; rd_i = 1'b1; rx_pe = 1'b1;
    @(negedge clk); rd_i = 1'b0; rx_pe = 1'b0;
    peek(ADDR_LSR, d); chk("lsr_pe_wins", d, 8'hE4);
    rd(ADDR_LSR, d); peek(ADDR_LSR, d); chk("lsr_clr2", d, 8'h60);

    wr(ADDR_IER, 8'h02);
    peek(ADDR_IIR, d); chk("iir_thre_ier", d, 8'h02);
    rd(ADDR_IIR, d); chk("iir_thre_rd", d, 8'h02);
    peek(ADDR_IIR, d); chk("iir_thre_rdclr", d, 8'h01);
    @(negedge clk); tx_fifo_empty_i = 1'b0;
    @(negedge clk); tx_fifo_empty_i = 1'b1;
    @(negedge clk); peek(ADDR_IIR, d); chk("iir_thre_edge", d, 8'h02);
    @(negedge clk); addr_i = ADDR_RBR; din_i = 8'h11; wr_i = 1'b1;
    #1 chk("tx_push_hi", tx_push_o, 1'b1);
    @(negedge clk); wr_i = 1'b0;
    #1 chk("tx_push_lo", tx_push_o, 1'b0);
    peek(ADDR_IIR, d); chk("iir_thr_wrclr", d, 8'h01);

    @(negedge clk); addr_i = ADDR_RBR; rd_i = 1'b1;
    #1 chk("pop_empty", rx_pop_o, 1'b0);
    rx_fifo_empty_i = 1'b0;
    #1 chk("pop_full", rx_pop_o, 1'b1);
    chk("rbr_rd", dout_o, 8'h5A);
    @(negedge clk); rd_i = 1'b0; rx_fifo_empty_i = 1'b1;

    wr(ADDR_IIR, 8'hC6);
    chk("fcr_pulse", {rx_rst, tx_rst}, 2'b11);
    chk("fcr_thresh14", rx_fifo_threshold, 4'd14);
    @(negedge clk); chk("fcr_pulse_end", {rx_rst, tx_rst}, 2'b00);
    wr(ADDR_IER, 8'h01);
    rx_fifo_count_i = 5'd13; peek(ADDR_IIR, d); chk("iir_cnt13", d, 8'h01);
    rx_fifo_count_i = 5'd14; peek(ADDR_IIR, d); chk("iir_cnt14", d, 8'h04);
    @(negedge clk); chk("irq_rx", irq_o, 1'b1);
    wr(ADDR_IER, 8'h05);
    @(negedge clk); rx_oe = 1'b1; @(negedge clk); rx_oe = 1'b0;
    peek(ADDR_IIR, d); chk("iir_rls_over_rx", d, 8'h06);
    peek(ADDR_LSR, d); chk("lsr_oe", d, 8'hE2);
    wr(ADDR_IIR, 8'h40); chk("fcr_thresh4", rx_fifo_threshold, 4'd4);

    @(negedge clk); rst = 1'b1;
    #1 chk("arst_irq", irq_o, 1'b0);
    chk("arst_thresh", rx_fifo_threshold, 4'd1);
    chk("arst_err", csr.lsr_err, 4'h0);
    peek(ADDR_LCR, d); chk("arst_lcr", d, 8'h03);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_regs_p.md
UART_REGS_P -- requirements
Module: uart_regs_p

Interface
REQ-001 SHALL have parameter DIV_W, default 16, divisor width, legal 16..24.
REQ-002 SHALL have parameter FRAC_W, default 4, fractional-divisor width.
REQ-003 SHALL have ports clk in 1 (sole clock) and rst in 1 (reset); reset is asynchronous and active-high.
REQ-004 SHALL have ports wr_i in 1 (write strobe), rd_i in 1 (read strobe), addr_i in 4 (register address), din_i in 8 (write data).
REQ-005 SHALL have ports rx_fifo_empty_i in 1, rx_fifo_in in 8 (RX FIFO head), rx_fifo_count_i in 5, tx_fifo_empty_i in 1, tx_idle_i in 1.
REQ-006 SHALL have ports rx_oe, rx_pe, rx_fe, rx_bi, each in 1, single-cycle error pulses.
REQ-007 SHALL have ports tx_push_o out 1, rx_pop_o out 1, baud_out out 1, tx_rst out 1, rx_rst out 1.
REQ-008 SHALL have ports rx_fifo_threshold out 4, dout_o out 8, irq_o out 1, csr out csr_t (register snapshot).

Function
REQ-009 Map: 0 RBR/THR (DLL if DLAB), 1 IER (DLM if DLAB), 2 IIR rd/FCR wr, 3 LCR, 4 MCR, 5 LSR ro, 6 MSR reads 0, 7 SCR, 8 DLX (divisor bits DIV_W-1:16), 9 FRAC; DLAB = LCR[7].
REQ-010 Writes SHALL take effect at the clk edge with wr_i high; unmapped writes are ignored; unmapped reads return 0.
REQ-011 dout_o SHALL be combinational from addr_i; addr 0 with DLAB=0 returns rx_fifo_in.
REQ-012 tx_push_o = wr_i & addr 0 & !DLAB, combinational, same cycle.
REQ-013 rx_pop_o = rd_i & addr 0 & !DLAB & !rx_fifo_empty_i; read of an empty FIFO SHALL NOT pop.
REQ-014 FCR write: bit1 SHALL produce a one-cycle rx_rst pulse and bit2 a one-cycle tx_rst pulse on the following cycle; bits 7:6 SHALL set rx_fifo_threshold to 1/4/8/14.
REQ-015 LSR: bit0 = !rx_fifo_empty_i; bits 1..4 = sticky OE/PE/FE/BI; bit5 = tx_fifo_empty_i; bit6 = tx_fifo_empty_i & tx_idle_i; bit7 = OR of sticky bits.
REQ-016 LSR read SHALL clear sticky bits on the next edge; an error pulse coincident with the read SHALL win, and the bit remains set.
REQ-017 Baud counter (DIV_W bits) SHALL pulse baud_out for one cycle every D cycles, where D is the divisor; D=0 yields no pulses; D=1 yields a pulse every cycle.
REQ-018 Any divisor-byte write SHALL reload the counter, so the first pulse falls D cycles after the write.
REQ-019 IIR priority: RLS (IER[2] & LSR[7]) reads 0x06 > RX (IER[0] & rx_fifo_count_i >= threshold) reads 0x04 > THRE (IER[1] & pending) reads 0x02 > none reads 0x01.
REQ-020 THRE pending SHALL set on the rising edge of tx_fifo_empty_i or an IER[1] 0->1 write with the FIFO empty, and clear on a THR write or on an IIR read that returns 0x02.
REQ-021 irq_o SHALL be registered and equal (IIR[0]==0), one cycle behind its cause.
REQ-022 csr SHALL reflect all stored registers each cycle.

Reset
REQ-023 Reset SHALL set LCR=0x03, divisor=0, FRAC=0, IER/MCR/SCR=0, sticky bits=0, THRE pending=0, threshold=1, baud_out/tx_rst/rx_rst/irq_o=0, and IIR reads 0x01.
REQ-024 Reset asserted mid-count SHALL clear the counter and the fractional accumulator immediately.

Configuration
REQ-025 With UART_REGS_FRAC_EN defined, FRAC[FRAC_W-1:0] SHALL be added to a FRAC_W accumulator on each baud pulse, and an accumulator carry SHALL stretch the next period to D+1 cycles.
REQ-026 Without UART_REGS_FRAC_EN, addr 9 SHALL be unmapped, and the period SHALL be exactly D.

Structure
REQ-027 Package uart_pkg SHALL hold csr_t, the register address constants, IIR code constants, and the threshold decode function.
REQ-028 Sub-module uart_baud_gen (counter plus optional fractional accumulator) SHALL be instantiated once.

Verification
REQ-029 Write LCR=0x80, DLL=0x08, DLM=0x01, LCR=0x00 -> baud_out pulses every 264 cycles.
REQ-030 Divisor 1, then divisor 0 -> a pulse every cycle, then no pulses.
REQ-031 FRAC_EN, D=4, FRAC=8 -> pulse periods alternate 4,5,4,5.
REQ-032 rx_pe pulse, IER=0x04 -> IIR reads 0x06 and irq_o=1; LSR read -> LSR[2]=0 and IIR reads 0x01; rx_pe coincident with the read -> LSR[2] stays 1.
REQ-033 FCR=0xC6 -> rx_rst and tx_rst pulse once, and rx_fifo_threshold=14; count 14 with IER[0]=1 -> IIR reads 0x04.
REQ-034 rd_i at addr 0 with rx_fifo_empty_i=1 -> rx_pop_o=0; THR write -> tx_push_o=1 for one cycle.
